bus_seq_ctrl: RTL and testbench

Parametrised control sequencer and common-bus controller for the basic computer. It owns the sequence counter (SC), decodes opcode and the I bit from IR, and drives the 3-bit bus select, a one-hot source vector and all register load/increment strobes for fetch, decode, indirect and memory-reference execution. It stalls on a memory ready handshake and supports halt/restart, with an optional interrupt cycle.

---
 rtl/bus_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_bus_seq_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_seq_ctrl.sv
// bus_seq_ctrl -- control sequencer and common-bus controller for the basic computer.
//
// Owns the sequence counter (SC), latches the opcode decode (d) and indirect bit (i)
// from IR at T2, and drives bus select, one-hot bus source, memory requests and all
// register strobes for fetch, decode, indirect and memory-reference execution.
// Memory steps stall on mem_rdy. HLT returns to the halted state, start resumes.
//
// Optional feature: define BUS_INTR_EN to add the interrupt cycle (R flip-flop,
// INTR state, ports ien/irq/ld_tr/clr_ar/clr_pc/ien_clr).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ir              instruction register contents (I | opcode | address)
//   start           leaves the halted state (ignored while running)
//   mem_rdy         memory handshake, completes the current memory step
//   ien, irq        interrupt enable / request            (BUS_INTR_EN only)
//   bus_sel         bus source: 0 none,1 AR,2 PC,3 DR,4 AC,5 IR,6 TR,7 MEM
//   bus_src         one-hot of bus_sel
//   mem_rd, mem_wr  memory access request, held for the whole step
//   ld_*, inr_*     register strobes, asserted only in the completing cycle
//   rr_exec,io_exec register-reference / I/O execution strobes
//   ld_tr, clr_ar, clr_pc, ien_clr  interrupt-cycle strobes (BUS_INTR_EN only)
//   d_out, i_out    latched opcode decode and I bit
//   sc_out          current timing step
//   running         sequencer active
//   seq_err         sticky SC overflow flag
module bus_seq_ctrl #(
    parameter int DATA_W = 16,
    parameter int SC_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ir,
    input  logic              start,
    input  logic              mem_rdy,
`ifdef BUS_INTR_EN
    input  logic              ien,
    input  logic              irq,
`endif
    output logic [2:0]        bus_sel,
    output logic [7:0]        bus_src,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              ld_ar,
    output logic              ld_pc,
    output logic              ld_dr,
    output logic              ld_ir,
    output logic              inr_pc,
    output logic              inr_ar,
    output logic              rr_exec,
    output logic              io_exec,
`ifdef BUS_INTR_EN
    output logic              ld_tr,
    output logic              clr_ar,
    output logic              clr_pc,
    output logic              ien_clr,
`endif
    output logic [7:0]        d_out,
    output logic              i_out,
    output logic [SC_W-1:0]   sc_out,
    output logic              running,
    output logic              seq_err
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_INTR = 2'd2
    } state_t;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
`ifdef BUS_INTR_EN
    localparam logic [2:0] BUS_TR   = 3'd6;
`endif
    localparam logic [2:0] BUS_MEM  = 3'd7;

    state_t          state_q, state_d;
    logic [SC_W-1:0] sc_q, sc_d;
    logic [7:0]      d_q, d_d;
    logic            i_q, i_d;
    logic            err_q, err_d;
`ifdef BUS_INTR_EN
    logic            r_q, r_d;
    logic            r_set;
`endif

    logic clr;       // this step ends the instruction (SC <- 0)
    logic halt_now;  // HLT seen at T3
    logic done;      // current step completes this cycle

    // Only ir[0] (HLT) and the I/opcode fields are used here.
    logic unused_ir;
    assign unused_ir = ^ir[DATA_W-5:1];

    always_comb begin
        bus_sel  = BUS_NONE;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        ld_ar    = 1'b0;
        ld_pc    = 1'b0;
        ld_dr    = 1'b0;
        ld_ir    = 1'b0;
        inr_pc   = 1'b0;
        inr_ar   = 1'b0;
        rr_exec  = 1'b0;
        io_exec  = 1'b0;
`ifdef BUS_INTR_EN
        ld_tr    = 1'b0;
        clr_ar   = 1'b0;
        clr_pc   = 1'b0;
        ien_clr  = 1'b0;
        r_d      = r_q;
        r_set    = 1'b0;
`endif
        state_d  = state_q;
        sc_d     = sc_q;
        d_d      = d_q;
        i_d      = i_q;
        err_d    = err_q;
        clr      = 1'b0;
        halt_now = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_HALT: begin
                if (start) begin
                    state_d = S_RUN;
                    sc_d    = '0;
                end
            end

            S_RUN: begin
                case (sc_q)
                    SC_W'(0): begin
                        bus_sel = BUS_PC;
                        ld_ar   = 1'b1;
                    end
                    SC_W'(1): begin
                        bus_sel = BUS_MEM;
                        mem_rd  = 1'b1;
                        ld_ir   = mem_rdy;
                        inr_pc  = mem_rdy;
                    end
                    SC_W'(2): begin
                        bus_sel = BUS_IR;
                        ld_ar   = 1'b1;
                        d_d     = 8'(1) << ir[DATA_W-2 -: 3];
                        i_d     = ir[DATA_W-1];
                    end
                    SC_W'(3): begin
                        if (d_q[7]) begin
                            clr = 1'b1;
                            if (!i_q) begin
                                rr_exec  = 1'b1;
                                halt_now = ir[0];  // HLT sampled straight from IR
                            end else begin
                                io_exec  = 1'b1;
                            end
                        end else if (i_q) begin
                            bus_sel = BUS_MEM;     // indirect: AR <- M[AR]
                            mem_rd  = 1'b1;
                            ld_ar   = mem_rdy;
                        end
                    end
                    SC_W'(4): begin
                        if (d_q[0] || d_q[1] || d_q[2] || d_q[6]) begin
                            bus_sel = BUS_MEM;
                            mem_rd  = 1'b1;
                            ld_dr   = mem_rdy;
                        end else if (d_q[3]) begin
                            bus_sel = BUS_AC;
                            mem_wr  = 1'b1;
                            clr     = 1'b1;
                        end else if (d_q[4]) begin
                            bus_sel = BUS_AR;
                            ld_pc   = 1'b1;
                            clr     = 1'b1;
                        end else if (d_q[5]) begin
                            bus_sel = BUS_PC;
                            mem_wr  = 1'b1;
                            inr_ar  = mem_rdy;
                        end
                    end
                    SC_W'(5): begin
                        if (d_q[0] || d_q[1] || d_q[2]) begin
                            clr = 1'b1;
                        end else if (d_q[5]) begin
                            bus_sel = BUS_AR;
                            ld_pc   = 1'b1;
                            clr     = 1'b1;
                        end
                    end
                    SC_W'(6): begin
                        if (d_q[6]) begin
                            bus_sel = BUS_DR;
                            mem_wr  = 1'b1;
                            clr     = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

`ifdef BUS_INTR_EN
            S_INTR: begin
                case (sc_q)
                    SC_W'(0): begin
                        bus_sel = BUS_PC;
                        ld_tr   = 1'b1;
                        clr_ar  = 1'b1;
                    end
                    SC_W'(1): begin
                        bus_sel = BUS_TR;
                        mem_wr  = 1'b1;
                        clr_pc  = mem_rdy;
                    end
                    default: begin
                        inr_pc  = 1'b1;
                        ien_clr = 1'b1;
                        clr     = 1'b1;
                    end
                endcase
            end
`endif

            default: state_d = S_HALT;
        endcase

        // Step completion and SC advance, shared by RUN and INTR.
        if (state_q != S_HALT) begin
            done = !(mem_rd || mem_wr) || mem_rdy;
            if (done) begin
`ifdef BUS_INTR_EN
                r_set = (state_q == S_RUN) && (sc_q >= SC_W'(3)) && ien && irq;
                if (state_q == S_INTR && clr) r_d = 1'b0;
                else                          r_d = r_q | r_set;
`endif
                if (clr) begin
                    sc_d = '0;
                    if (halt_now) begin
                        state_d = S_HALT;
`ifdef BUS_INTR_EN
                    end else if (state_q == S_INTR) begin
                        state_d = S_RUN;
                    end else if (r_q || r_set) begin
                        state_d = S_INTR;
`endif
                    end
                end else if (sc_q == '1) begin
                    err_d = 1'b1;
                    sc_d  = '0;
                end else begin
                    sc_d  = sc_q + SC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HALT;
            sc_q    <= '0;
            d_q     <= '0;
            i_q     <= 1'b0;
            err_q   <= 1'b0;
`ifdef BUS_INTR_EN
            r_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            d_q     <= d_d;
            i_q     <= i_d;
            err_q   <= err_d;
`ifdef BUS_INTR_EN
            r_q     <= r_d;
`endif
        end
    end

    assign bus_src = 8'(1) << bus_sel;
    assign d_out   = d_q;
    assign i_out   = i_q;
    assign sc_out  = sc_q;
    assign running = (state_q != S_HALT);
    assign seq_err = err_q;

endmodule

// File: tb/tb_bus_seq_ctrl.sv
// Testbench for bus_seq_ctrl: directed instruction sequences, checked every cycle
// against a step-list model of the instruction timing plus literal expectations.
module tb_bus_seq_ctrl;
    localparam int DATA_W = 16;
    localparam int SC_W   = 3;

    logic        clk = 1'b0;
    logic        rst_n, start, mem_rdy, ien, irq;
    logic [15:0] ir;

    logic [2:0]  bus_sel;
    logic [7:0]  bus_src, d_out;
    logic        mem_rd, mem_wr, ld_ar, ld_pc, ld_dr, ld_ir, inr_pc, inr_ar;
    logic        rr_exec, io_exec, i_out, running, seq_err;
    logic        ld_tr, clr_ar, clr_pc, ien_clr;
    logic [SC_W-1:0] sc_out;

    bus_seq_ctrl #(.DATA_W(DATA_W), .SC_W(SC_W)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .start(start), .mem_rdy(mem_rdy),
`ifdef BUS_INTR_EN
        .ien(ien), .irq(irq),
`endif
        .bus_sel(bus_sel), .bus_src(bus_src), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .ld_ar(ld_ar), .ld_pc(ld_pc), .ld_dr(ld_dr), .ld_ir(ld_ir),
        .inr_pc(inr_pc), .inr_ar(inr_ar), .rr_exec(rr_exec), .io_exec(io_exec),
`ifdef BUS_INTR_EN
        .ld_tr(ld_tr), .clr_ar(clr_ar), .clr_pc(clr_pc), .ien_clr(ien_clr),
`endif
        .d_out(d_out), .i_out(i_out), .sc_out(sc_out), .running(running),
        .seq_err(seq_err)
    );

`ifndef BUS_INTR_EN
    assign ld_tr   = 1'b0;
    assign clr_ar  = 1'b0;
    assign clr_pc  = 1'b0;
    assign ien_clr = 1'b0;
`endif

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Strobe bit positions in the packed strobe vector.
    localparam logic [11:0] S_LDAR  = 12'h001;
    localparam logic [11:0] S_LDPC  = 12'h002;
    localparam logic [11:0] S_LDDR  = 12'h004;
    localparam logic [11:0] S_LDIR  = 12'h008;
    localparam logic [11:0] S_INRPC = 12'h010;
    localparam logic [11:0] S_INRAR = 12'h020;
    localparam logic [11:0] S_RR    = 12'h040;
    localparam logic [11:0] S_IO    = 12'h080;
    localparam logic [11:0] S_LDTR  = 12'h100;
    localparam logic [11:0] S_CLRAR = 12'h200;
    localparam logic [11:0] S_CLRPC = 12'h400;
    localparam logic [11:0] S_IENCL = 12'h800;

    function automatic logic [11:0] dut_stb();
        return {ien_clr, clr_pc, clr_ar, ld_tr, io_exec, rr_exec,
                inr_ar, inr_pc, ld_ir, ld_dr, ld_pc, ld_ar};
    endfunction

    // Model: each instruction is a list of steps; a step with a memory request
    // repeats until mem_rdy, its strobes appear only in the completing cycle.
    typedef struct packed {
        logic [2:0]  bus;
        logic        rd;
        logic        wr;
        logic [11:0] stb;
        logic        last;
    } step_t;

    step_t       prog[$];
    int          m_mode = 0;   // 0 halted, 1 running, 2 interrupt cycle
    int          m_sc   = 0;
    logic [7:0]  m_d    = '0;
    logic        m_i    = 1'b0;
    logic        m_r    = 1'b0;

    function automatic step_t mk(logic [2:0] bus, logic rd, logic wr, logic [11:0] stb, logic last);
        step_t s;
        s.bus = bus; s.rd = rd; s.wr = wr; s.stb = stb; s.last = last;
        return s;
    endfunction

    function automatic void load_fetch();
        prog.delete();
        prog.push_back(mk(3'd2, 1'b0, 1'b0, S_LDAR, 1'b0));
        prog.push_back(mk(3'd7, 1'b1, 1'b0, S_LDIR | S_INRPC, 1'b0));
        prog.push_back(mk(3'd5, 1'b0, 1'b0, S_LDAR, 1'b0));
    endfunction

    function automatic void load_intr();
        prog.delete();
        prog.push_back(mk(3'd2, 1'b0, 1'b0, S_LDTR | S_CLRAR, 1'b0));
        prog.push_back(mk(3'd6, 1'b0, 1'b1, S_CLRPC, 1'b0));
        prog.push_back(mk(3'd0, 1'b0, 1'b0, S_INRPC | S_IENCL, 1'b1));
    endfunction

    function automatic void push_exec(logic [15:0] w);
        logic [2:0] op;
        op = w[14:12];
        if (op == 3'd7) begin
            prog.push_back(mk(3'd0, 1'b0, 1'b0, w[15] ? S_IO : S_RR, 1'b1));
            return;
        end
        if (w[15]) prog.push_back(mk(3'd7, 1'b1, 1'b0, S_LDAR, 1'b0));
        else       prog.push_back(mk(3'd0, 1'b0, 1'b0, 12'h0, 1'b0));
        case (op)
            3'd0, 3'd1, 3'd2: begin
                prog.push_back(mk(3'd7, 1'b1, 1'b0, S_LDDR, 1'b0));
                prog.push_back(mk(3'd0, 1'b0, 1'b0, 12'h0, 1'b1));
            end
            3'd3: prog.push_back(mk(3'd4, 1'b0, 1'b1, 12'h0, 1'b1));
            3'd4: prog.push_back(mk(3'd1, 1'b0, 1'b0, S_LDPC, 1'b1));
            3'd5: begin
                prog.push_back(mk(3'd2, 1'b0, 1'b1, S_INRAR, 1'b0));
                prog.push_back(mk(3'd1, 1'b0, 1'b0, S_LDPC, 1'b1));
            end
            default: begin
                prog.push_back(mk(3'd7, 1'b1, 1'b0, S_LDDR, 1'b0));
                prog.push_back(mk(3'd0, 1'b0, 1'b0, 12'h0, 1'b0));
                prog.push_back(mk(3'd3, 1'b0, 1'b1, 12'h0, 1'b1));
            end
        endcase
    endfunction

    // Compare on the falling edge, then advance the model to the state the
    // DUT will hold after the next rising edge.
    always @(negedge clk) begin : model_cmp
        step_t       cur;
        logic        done;
        logic [2:0]  e_bus;
        logic [11:0] e_stb;
        if (!rst_n) begin
            m_mode = 0; m_sc = 0; m_d = '0; m_i = 1'b0; m_r = 1'b0;
            prog.delete();
        end
        cur  = '0;
        done = 1'b0;
        if (m_mode != 0 && prog.size() == 0) begin
            errors++;
            $display("FAIL model_queue: running with no step pending at %0t", $time);
            m_mode = 0;
        end
        if (m_mode == 0) begin
            e_bus = 3'd0;
            e_stb = 12'h0;
        end else begin
            cur   = prog[0];
            done  = !(cur.rd || cur.wr) || mem_rdy;
            e_bus = cur.bus;
            e_stb = done ? cur.stb : 12'h0;
        end
        chk("bus_sel", bus_sel, e_bus);
        chk("bus_src", bus_src, 8'(1) << e_bus);
        chk("mem_rd",  mem_rd,  cur.rd);
        chk("mem_wr",  mem_wr,  cur.wr);
        chk("strobes", dut_stb(), e_stb);
        chk("sc_out",  sc_out,  m_sc);
        chk("running", running, m_mode != 0);
        chk("d_out",   d_out,   m_d);
        chk("i_out",   i_out,   m_i);
        chk("seq_err", seq_err, 1'b0);

        if (rst_n && m_mode == 0) begin
            if (start) begin
                m_mode = 1; m_sc = 0;
                load_fetch();
            end
        end else if (rst_n && done) begin
            void'(prog.pop_front());
            if (m_mode == 1 && m_sc == 2) begin
                m_d = 8'(1) << ir[14:12];
                m_i = ir[15];
                push_exec(ir);
            end
            if (m_mode == 1 && m_sc >= 3 && ien && irq) m_r = 1'b1;
            if (cur.last) begin
                m_sc = 0;
                if ((cur.stb & S_RR) != 0 && ir[0]) begin
                    m_mode = 0;
                    prog.delete();
                end else if (m_mode == 2) begin
                    m_mode = 1; m_r = 1'b0;
                    load_fetch();
                end else if (m_r) begin
                    m_mode = 2;
                    load_intr();
                end else begin
                    load_fetch();
                end
            end else begin
                m_sc++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  seq[6];
    logic [2:0]  want[6];
    logic [15:0] tab[9];
    int          idx;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; mem_rdy = 1'b1; ien = 1'b0; irq = 1'b0; ir = 16'h0;
        want = '{3'd2, 3'd7, 3'd5, 3'd0, 3'd7, 3'd0};
        tab  = '{16'h3001, 16'h4005, 16'hF800, 16'h0123, 16'h9040,
                 16'h6010, 16'hB020, 16'h1111, 16'hE044};
        @(negedge clk);
        chk("rst_bus_src", bus_src, 8'h01);
        chk("rst_running", running, 1'b0);
        chk("rst_sc",      sc_out,  0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // LDA direct
        ir = 16'h2123; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seq[k] = bus_sel;
            if (k == 4) chk("lda_ld_dr_t4", ld_dr, 1'b1);
            cyc();
        end
        for (int k = 0; k < 6; k++) chk("lda_bus_seq", seq[k], want[k]);

        // LDA indirect with two wait cycles at T3
        ir = 16'hA050;
        @(negedge clk);
        chk("lda_sc_wrap", sc_out, 0);
        cyc(); cyc(); cyc();
        mem_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) mem_rdy = 1'b1;
            @(negedge clk);
            chk("ind_sc_hold", sc_out, 3);
            chk("ind_ld_ar",   ld_ar, k == 2);
            cyc();
        end
        cyc(); cyc();

        // BSA
        ir = 16'h5010;
        cyc(); cyc(); cyc(); cyc();
        @(negedge clk);
        chk("bsa_t4_wr",  mem_wr,  1'b1);
        chk("bsa_t4_bus", bus_sel, 3'd2);
        chk("bsa_t4_inr", inr_ar,  1'b1);
        cyc();
        @(negedge clk);
        chk("bsa_t5_ldpc", ld_pc,   1'b1);
        chk("bsa_t5_bus",  bus_sel, 3'd1);
        cyc();

        // HLT then restart
        ir = 16'h7001;
        cyc(); cyc(); cyc();
        @(negedge clk);
        chk("hlt_rr", rr_exec, 1'b1);
        cyc();
        @(negedge clk);
        chk("hlt_running", running, 1'b0);
        chk("hlt_strobes", dut_stb(), 12'h0);
        chk("hlt_bus",     bus_sel, 3'd0);
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        @(negedge clk);
        chk("restart_sc",  sc_out,  0);
        chk("restart_run", running, 1'b1);
        chk("restart_bus", bus_sel, 3'd2);

        // ISZ, stray start pulse, then reset during T5
        ir = 16'h6010;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc(); cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_bus_sel", bus_sel, 3'd0);
        chk("arst_bus_src", bus_src, 8'h01);
        chk("arst_mem",     {mem_rd, mem_wr}, 2'b00);
        chk("arst_strobes", dut_stb(), 12'h0);
        chk("arst_d_i",     {d_out, i_out}, 9'h0);
        chk("arst_sc",      sc_out, 0);
        chk("arst_running", running, 1'b0);
        chk("arst_seq_err", seq_err, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Instruction mix with periodic memory wait states
        start = 1'b1;
        cyc();
        start = 1'b0;
        idx = 0;
        ir  = tab[0];
        for (int k = 0; k < 400 && idx < 9; k++) begin
            mem_rdy = (k % 4 != 2);
            cyc();
            if (m_mode == 1 && m_sc == 0) begin
                idx++;
                if (idx < 9) ir = tab[idx];
            end
        end
        chk("mix_completed", idx, 9);
        mem_rdy = 1'b1;

`ifdef BUS_INTR_EN
        // Interrupt request at T4 of STA
        ir = 16'h3001; ien = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        irq = 1'b1;
        cyc();
        irq = 1'b0;
        @(negedge clk);
        chk("rt0_bus",   bus_sel, 3'd2);
        chk("rt0_ld_tr", ld_tr, 1'b1);
        cyc();
        @(negedge clk);
        chk("rt1_bus", bus_sel, 3'd6);
        chk("rt1_wr",  mem_wr, 1'b1);
        cyc();
        @(negedge clk);
        chk("rt2_bus",     bus_sel, 3'd0);
        chk("rt2_ien_clr", ien_clr, 1'b1);
        cyc();
        @(negedge clk);
        chk("post_intr_bus", bus_sel, 3'd2);
        chk("post_intr_sc",  sc_out, 0);
        ien = 1'b0;
`endif

        cyc(); cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
